// File: rtl/se_pkg.sv
// Shared types and constants for the SE request arbiter and the benches around it.
package se_pkg;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 128;
    localparam int INST_W  = 8;
    localparam int LAT_W   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } se_state_e;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [DATA_W-1:0] cond;
    } se_req_t;

    // One-hot select vector for a requester index.
    function automatic logic [NUM_REQ-1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/se_req_arbiter_if.sv
// Requester-side and SE-side handshake buses of the arbiter.
interface se_req_if import se_pkg::*; #(
    parameter int DATA_W = se_pkg::DATA_W,
    parameter int INST_W = se_pkg::INST_W
);
    logic [2*INST_W-1:0] req_inst;
    logic [2*DATA_W-1:0] req_op1;
    logic [2*DATA_W-1:0] req_op2;
    logic [2*DATA_W-1:0] req_cond;
    logic [1:0]          req_in_valid;
    logic [1:0]          req_in_ready;
    logic [DATA_W-1:0]   req_out_result;
    logic [1:0]          req_out_valid;
    logic [1:0]          req_out_ready;

    modport master (
        output req_inst, req_op1, req_op2, req_cond, req_in_valid, req_out_ready,
        input  req_in_ready, req_out_result, req_out_valid
    );
    modport slave (
        input  req_inst, req_op1, req_op2, req_cond, req_in_valid, req_out_ready,
        output req_in_ready, req_out_result, req_out_valid
    );
endinterface

interface se_unit_if import se_pkg::*; #(
    parameter int DATA_W = se_pkg::DATA_W,
    parameter int INST_W = se_pkg::INST_W
);
    logic [INST_W-1:0] se_in_inst;
    logic [DATA_W-1:0] se_in_op1;
    logic [DATA_W-1:0] se_in_op2;
    logic [DATA_W-1:0] se_in_cond;
    logic              se_in_valid;
    logic              se_in_ready;
    logic [DATA_W-1:0] se_out_result;
    logic              se_out_valid;
    logic              se_out_ready;

    modport master (
        output se_in_inst, se_in_op1, se_in_op2, se_in_cond, se_in_valid, se_out_ready,
        input  se_in_ready, se_out_result, se_out_valid
    );
    modport slave (
        input  se_in_inst, se_in_op1, se_in_op2, se_in_cond, se_in_valid, se_out_ready,
        output se_in_ready, se_out_result, se_out_valid
    );
endinterface

// File: rtl/se_rr_grant.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the pointer.
module se_rr_grant import se_pkg::*; (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic               ptr_i,
    output logic [NUM_REQ-1:0] grant_o
);

    // Grant decode
    always_comb begin
        grant_o = 2'b00;
        case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = req_onehot(ptr_i);
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/se_req_arbiter.sv
// Shares one SE between two requesters: one operation in flight, round-robin
// arbitration, and issue-to-result latency capture.
module se_req_arbiter import se_pkg::*; #(
    parameter int DATA_W = se_pkg::DATA_W,
    parameter int INST_W = se_pkg::INST_W,
    parameter int LAT_W  = se_pkg::LAT_W
) (
    input  logic             clock,
    input  logic             reset,
    se_req_if.slave          req,
    se_unit_if.master        se,
    output logic [LAT_W-1:0] last_latency,
    output logic             last_owner,
    output logic             busy
);

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [DATA_W-1:0] cond;
    } req_t;

    se_state_e         state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              owner_q, owner_d;
    req_t              req_q, req_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    logic [LAT_W-1:0]  last_lat_q, last_lat_d;
    logic              last_owner_q, last_owner_d;

    logic [1:0]        grant_s;
    req_t              pick_s;
    logic [1:0]        in_ready_s;
    logic [1:0]        out_valid_s;
    logic              se_in_valid_s;
    logic              se_out_ready_s;

    function automatic logic [LAT_W-1:0] sat_inc(input logic [LAT_W-1:0] v);
        return (&v) ? v : v + LAT_W'(1);
    endfunction

    se_rr_grant u_grant (
        .valid_i (req.req_in_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant_s)
    );

    // Select the winning requester's slice of the packed request buses
    always_comb begin
        pick_s = '0;
        if (grant_s[1]) begin
            pick_s.inst = req.req_inst[INST_W +: INST_W];
            pick_s.op1  = req.req_op1[DATA_W +: DATA_W];
            pick_s.op2  = req.req_op2[DATA_W +: DATA_W];
            pick_s.cond = req.req_cond[DATA_W +: DATA_W];
        end else begin
            pick_s.inst = req.req_inst[0 +: INST_W];
            pick_s.op1  = req.req_op1[0 +: DATA_W];
            pick_s.op2  = req.req_op2[0 +: DATA_W];
            pick_s.cond = req.req_cond[0 +: DATA_W];
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        owner_d        = owner_q;
        req_d          = req_q;
        result_d       = result_q;
        cnt_d          = cnt_q;
        last_lat_d     = last_lat_q;
        last_owner_d   = last_owner_q;
        in_ready_s     = 2'b00;
        out_valid_s    = 2'b00;
        se_in_valid_s  = 1'b0;
        se_out_ready_s = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_s = grant_s;
                if (|grant_s) begin
                    req_d   = pick_s;
                    owner_d = grant_s[1];
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                se_in_valid_s = 1'b1;
                if (se.se_in_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    state_d = ISSUE;
                end
            end
            WAIT: begin
                se_out_ready_s = 1'b1;
                // The result cycle itself counts, so a next-cycle result reads as 1.
                if (se.se_out_valid) begin
                    result_d     = se.se_out_result;
                    last_lat_d   = sat_inc(cnt_q);
                    last_owner_d = owner_q;
                    state_d      = RESP;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            RESP: begin
                out_valid_s = req_onehot(owner_q);
                if (req.req_out_ready[owner_q]) begin
                    ptr_d   = ~owner_q;
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            ptr_q        <= 1'b0;
            owner_q      <= 1'b0;
            req_q        <= '0;
            result_q     <= '0;
            cnt_q        <= '0;
            last_lat_q   <= '0;
            last_owner_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            req_q        <= req_d;
            result_q     <= result_d;
            cnt_q        <= cnt_d;
            last_lat_q   <= last_lat_d;
            last_owner_q <= last_owner_d;
        end
    end

    assign req.req_in_ready   = in_ready_s;
    assign req.req_out_valid  = out_valid_s;
    assign req.req_out_result = result_q;
    assign se.se_in_inst      = req_q.inst;
    assign se.se_in_op1       = req_q.op1;
    assign se.se_in_op2       = req_q.op2;
    assign se.se_in_cond      = req_q.cond;
    assign se.se_in_valid     = se_in_valid_s;
    assign se.se_out_ready    = se_out_ready_s;
    assign last_latency       = last_lat_q;
    assign last_owner         = last_owner_q;
    assign busy               = (state_q != IDLE);

endmodule

// File: tb/tb_se_req_arbiter.sv
// Scoreboard bench for se_req_arbiter: requester queues, a simple SE model
// computing op1*op2, and a response monitor checking per-requester results.
module tb_se_req_arbiter;
    import se_pkg::*;

    localparam int DW = 128;
    localparam int IW = 8;
    localparam int LW = 4;

    logic          clock;
    logic          reset;
    logic [LW-1:0] last_latency;
    logic          last_owner;
    logic          busy;

    se_req_if  #(.DATA_W(DW), .INST_W(IW)) rq ();
    se_unit_if #(.DATA_W(DW), .INST_W(IW)) su ();

    se_req_arbiter #(.DATA_W(DW), .INST_W(IW), .LAT_W(LW)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (rq),
        .se           (su),
        .last_latency (last_latency),
        .last_owner   (last_owner),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int              total;
    int              bad;
    int              n_done;
    int              acc_order[$];
    se_req_t         pend_q[2][$];
    logic [DW-1:0]   exp_q[2][$];
    int              se_rdy_dly;
    int              se_rsp_dly;
    bit              se_spur;
    int              hold[2];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_req(input int r, input logic [7:0] inst, input logic [127:0] a, input logic [127:0] b);
        se_req_t x;
        x.inst = inst;
        x.op1  = a;
        x.op2  = b;
        x.cond = a ^ b;
        pend_q[r].push_back(x);
        exp_q[r].push_back(a * b);
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (n_done < target && n < budget) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (n_done < target) begin
            bad++;
            $display("FAIL wait_done: got %0d responses expected %0d", n_done, target);
        end
    endtask

    // Requester drivers, response backpressure and SE model, all updated just after the rising edge
    initial begin
        logic [1:0]    acc;
        int            st, hc, rc;
        int            oh[2];
        se_req_t       snap;
        logic [DW-1:0] res;
        bit            stable;
        st = 0; hc = 0; rc = 0; oh[0] = 0; oh[1] = 0; snap = '0; res = '0;
        rq.req_inst = '0; rq.req_op1 = '0; rq.req_op2 = '0; rq.req_cond = '0;
        rq.req_in_valid = 2'b00; rq.req_out_ready = 2'b11;
        su.se_in_ready = 1'b0; su.se_out_valid = 1'b0; su.se_out_result = '0;
        forever begin
            @(negedge clock);
            acc = rq.req_in_valid & rq.req_in_ready & {2{reset}};
            @(posedge clock);
            #1;
            for (int r = 0; r < 2; r++) begin
                if (acc[r]) begin
                    void'(pend_q[r].pop_front());
                    acc_order.push_back(r);
                end
                if (pend_q[r].size() > 0) begin
                    rq.req_in_valid[r]        = 1'b1;
                    rq.req_inst[r*IW +: IW]   = pend_q[r][0].inst;
                    rq.req_op1[r*DW +: DW]    = pend_q[r][0].op1;
                    rq.req_op2[r*DW +: DW]    = pend_q[r][0].op2;
                    rq.req_cond[r*DW +: DW]   = pend_q[r][0].cond;
                end else begin
                    rq.req_in_valid[r] = 1'b0;
                end
                if (rq.req_out_valid[r] && oh[r] < hold[r]) begin
                    rq.req_out_ready[r] = 1'b0;
                    oh[r]++;
                    chk("held_in_ready", 128'(rq.req_in_ready), 128'(2'b00));
                    chk("held_out_valid", 128'(rq.req_out_valid), 128'(req_onehot(r[0])));
                    if (exp_q[r].size() > 0)
                        chk("held_result", rq.req_out_result, exp_q[r][0]);
                end else begin
                    rq.req_out_ready[r] = 1'b1;
                    if (!rq.req_out_valid[r]) oh[r] = 0;
                end
            end
            su.se_in_ready  = 1'b0;
            su.se_out_valid = 1'b0;
            if (!reset) begin
                st = 0;
            end else begin
                if (st == 0 && su.se_in_valid) begin
                    snap = {su.se_in_inst, su.se_in_op1, su.se_in_op2, su.se_in_cond};
                    hc = 0;
                    st = 1;
                end
                if (st == 1) begin
                    if (hc > 0) begin
                        stable = ({su.se_in_inst, su.se_in_op1, su.se_in_op2, su.se_in_cond} == snap);
                        chk("se_in_valid_held", 128'(su.se_in_valid), 128'(1'b1));
                        chk("se_in_stable", 128'(stable), 128'(1'b1));
                    end
                    if (hc == se_rdy_dly) begin
                        su.se_in_ready = 1'b1;
                        res = snap.op1 * snap.op2;
                        rc = 0;
                        st = 2;
                    end else begin
                        hc++;
                        if (se_spur && hc == 1) begin
                            su.se_out_valid  = 1'b1;
                            su.se_out_result = 128'hDEAD;
                            chk("spurious_out_ready", 128'(su.se_out_ready), 128'(1'b0));
                        end
                    end
                end else if (st == 2) begin
                    rc++;
                    if (rc >= se_rsp_dly) begin
                        su.se_out_valid  = 1'b1;
                        su.se_out_result = res;
                        st = 0;
                    end
                end
            end
        end
    end

    // Response monitor: pops the owner's expectation on every response handshake
    initial begin
        forever begin
            @(negedge clock);
            if (|rq.req_out_valid)
                chk("resp_onehot", 128'($countones(rq.req_out_valid)), 128'(1));
            for (int r = 0; r < 2; r++) begin
                if (rq.req_out_valid[r] && rq.req_out_ready[r]) begin
                    if (exp_q[r].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL resp_unexpected: requester %0d got %0h expected none", r, rq.req_out_result);
                    end else begin
                        chk($sformatf("resp_result_r%0d", r), rq.req_out_result, exp_q[r].pop_front());
                    end
                    n_done++;
                end
            end
        end
    end

    initial begin
        int n;
        total = 0; bad = 0; n_done = 0;
        se_rdy_dly = 0; se_rsp_dly = 1; se_spur = 1'b0; hold[0] = 0; hold[1] = 0;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_in_ready", 128'(rq.req_in_ready), 128'(2'b00));
        chk("rst_out_valid", 128'(rq.req_out_valid), 128'(2'b00));
        chk("rst_se_in_valid", 128'(su.se_in_valid), 128'(1'b0));
        chk("rst_se_out_ready", 128'(su.se_out_ready), 128'(1'b0));
        chk("rst_last_latency", 128'(last_latency), 128'(4'd0));
        chk("rst_last_owner", 128'(last_owner), 128'(1'b0));
        reset = 1'b1;

        // Single request, result 3 cycles after accept
        se_rdy_dly = 0; se_rsp_dly = 3;
        push_req(0, 8'h01, 128'd5, 128'd3);
        wait_done(1, 100);
        chk("single_latency", 128'(last_latency), 128'(4'd3));
        chk("single_owner", 128'(last_owner), 128'(1'b0));
        @(negedge clock);

        // Contention after reset: grant order 0,1,0,1
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        acc_order.delete();
        se_rsp_dly = 1;
        push_req(0, 8'h02, 128'd2, 128'd7);
        push_req(0, 8'h03, 128'd3, 128'd9);
        push_req(1, 8'h04, 128'd4, 128'd4);
        push_req(1, 8'h05, 128'd6, 128'd5);
        wait_done(5, 400);
        chk("contention_count", 128'(acc_order.size()), 128'(4));
        for (int i = 0; i < 4 && i < acc_order.size(); i++)
            chk($sformatf("contention_order_%0d", i), 128'(acc_order[i]), 128'(i % 2));

        // SE input backpressure plus owner response backpressure, other requester waiting
        se_rdy_dly = 5; se_rsp_dly = 2; hold[1] = 4;
        push_req(1, 8'h08, 128'd11, 128'd2);
        repeat (2) @(negedge clock);
        push_req(0, 8'h09, 128'd2, 128'd2);
        wait_done(6, 400);
        chk("bp_latency", 128'(last_latency), 128'(4'd2));
        chk("bp_owner", 128'(last_owner), 128'(1'b1));
        hold[1] = 0;
        wait_done(7, 400);
        chk("bp2_owner", 128'(last_owner), 128'(1'b0));

        // Spurious result during ISSUE must be ignored
        se_spur = 1'b1; se_rdy_dly = 3; se_rsp_dly = 4;
        push_req(1, 8'h10, 128'd6, 128'd6);
        wait_done(8, 400);
        chk("spur_latency", 128'(last_latency), 128'(4'd4));
        se_spur = 1'b0;

        // Latency saturation at 2^LW-1
        se_rdy_dly = 0; se_rsp_dly = 20;
        push_req(0, 8'h11, 128'd7, 128'd7);
        wait_done(9, 400);
        chk("sat_latency", 128'(last_latency), 128'(4'd15));
        chk("sat_owner", 128'(last_owner), 128'(1'b0));

        // Reset while waiting on the SE: operation dropped, pointer back to 0
        se_rsp_dly = 30;
        push_req(0, 8'h12, 128'd2, 128'd2);
        n = 0;
        while (su.se_out_ready !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("midrst_reached_wait", 128'(su.se_out_ready), 128'(1'b1));
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_busy", 128'(busy), 128'(1'b0));
        chk("midrst_out_valid", 128'(rq.req_out_valid), 128'(2'b00));
        chk("midrst_se_out_ready", 128'(su.se_out_ready), 128'(1'b0));
        reset = 1'b1;
        if (exp_q[0].size() > 0) void'(exp_q[0].pop_back());
        acc_order.delete();
        se_rsp_dly = 1;
        push_req(0, 8'h13, 128'd3, 128'd3);
        push_req(1, 8'h14, 128'd4, 128'd5);
        wait_done(11, 400);
        chk("midrst_count", 128'(acc_order.size()), 128'(2));
        if (acc_order.size() > 0)
            chk("midrst_first_grant", 128'(acc_order[0]), 128'(0));
        repeat (3) @(negedge clock);
        chk("exp_left", 128'(exp_q[0].size() + exp_q[1].size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
